// File: rtl/sha3_pkg.sv
// Shared Keccak rho/pi constants: lane rotation offsets, pi lane permutation
// and the lane-width legality check used by the rho/pi pipeline.
package sha3_pkg;

    localparam int NUM_LANES = 25;

    // Rotation offsets R(x,y), flattened as index y*5 + x.
    localparam int RHO_OFS [NUM_LANES] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    function automatic int lane_idx(input int x, input int y);
        return y * 5 + x;
    endfunction

    function automatic int rho_ofs(input int x, input int y);
        return RHO_OFS[lane_idx(x, y)];
    endfunction

    // Destination of lane (x,y) under pi: x' = y, y' = (2x + 3y) mod 5.
    function automatic int pi_dest(input int x, input int y);
        return lane_idx(y, (2 * x + 3 * y) % 5);
    endfunction

    function automatic bit lane_w_legal(input int w);
        case (w)
            8, 16, 32, 64: return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sha3_pipe_slot.sv
// One elastic pipeline stage: a 25-lane state register with its valid bit.
// Accepts a new beat whenever it is empty or its current beat leaves.
module sha3_pipe_slot
    import sha3_pkg::*;
#(
    parameter int LANE_W = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                up_valid,
    input  logic [NUM_LANES-1:0][LANE_W-1:0]    up_data,
    input  logic                                dn_ready,
    output logic                                valid,
    output logic [NUM_LANES-1:0][LANE_W-1:0]    data,
    output logic                                ready
);

    logic                               valid_r;
    logic [NUM_LANES-1:0][LANE_W-1:0]   data_r;
    logic                               ready_s;

    assign ready_s = !valid_r || dn_ready;
    assign ready   = ready_s;
    assign valid   = valid_r;
    assign data    = data_r;

    // Stage state: load on free slot, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else begin
            if (ready_s) begin
                valid_r <= up_valid;
            end else begin
                valid_r <= valid_r;
            end
            if (ready_s && up_valid) begin
                data_r <= up_data;
            end else begin
                data_r <= data_r;
            end
        end
    end

endmodule

// File: rtl/sha3_rho_pi.sv
// Keccak rho (and optional pi) step on a full state, followed by a DEPTH-deep
// elastic register pipeline with valid/ready handshake and occupancy count.
module sha3_rho_pi
    import sha3_pkg::*;
#(
    parameter int LANE_W = 64,
    parameter int DEPTH  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [4:0][LANE_W-1:0]          isa,
    input  logic [4:0][LANE_W-1:0]          isb,
    input  logic [4:0][LANE_W-1:0]          isc,
    input  logic [4:0][LANE_W-1:0]          isd,
    input  logic [4:0][LANE_W-1:0]          ise,
    input  logic                            sample,
    input  logic                            apply_pi,
    output logic                            ready,
    output logic [4:0][LANE_W-1:0]          osa,
    output logic [4:0][LANE_W-1:0]          osb,
    output logic [4:0][LANE_W-1:0]          osc,
    output logic [4:0][LANE_W-1:0]          osd,
    output logic [4:0][LANE_W-1:0]          ose,
    output logic                            good,
    input  logic                            ack,
    output logic [$clog2(DEPTH+1)-1:0]      count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef logic [NUM_LANES-1:0][LANE_W-1:0] state_t;

    if (!lane_w_legal(LANE_W)) begin : g_bad_lane_w
        $error("sha3_rho_pi: LANE_W must be 8, 16, 32 or 64");
    end
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("sha3_rho_pi: DEPTH must be in 1..4");
    end

    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int amt);
        logic [2*LANE_W-1:0] dbl;
        dbl = {v, v} << amt;
        return dbl[2*LANE_W-1:LANE_W];
    endfunction

    state_t in_s;
    state_t rho_s;
    state_t pi_s;
    state_t beat_s;

    assign in_s = {ise, isd, isc, isb, isa};

    // Rho rotation of every lane, then the pi lane permutation of the result.
    always_comb begin
        rho_s = '0;
        pi_s  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            rho_s[i] = rotl(in_s[i], RHO_OFS[i] % LANE_W);
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            pi_s[pi_dest(i % 5, i / 5)] = rho_s[i];
        end
    end

    // Per-beat mode select between rho-only and rho-then-pi.
    always_comb begin
        if (apply_pi) begin
            beat_s = pi_s;
        end else begin
            beat_s = rho_s;
        end
    end

    // Chain element k feeds slot k; element DEPTH is the pipeline output.
    logic   vld_s [DEPTH+1];
    logic   rdy_s [DEPTH+1];
    state_t dat_s [DEPTH+1];

    assign vld_s[0]     = sample;
    assign dat_s[0]     = beat_s;
    assign rdy_s[DEPTH] = ack;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        sha3_pipe_slot #(
            .LANE_W (LANE_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .up_valid (vld_s[k]),
            .up_data  (dat_s[k]),
            .dn_ready (rdy_s[k+1]),
            .valid    (vld_s[k+1]),
            .data     (dat_s[k+1]),
            .ready    (rdy_s[k])
        );
    end

    assign ready = rdy_s[0];
    assign good  = vld_s[DEPTH];
    assign osa   = dat_s[DEPTH][4:0];
    assign osb   = dat_s[DEPTH][9:5];
    assign osc   = dat_s[DEPTH][14:10];
    assign osd   = dat_s[DEPTH][19:15];
    assign ose   = dat_s[DEPTH][24:20];

    logic              in_fire_s;
    logic              out_fire_s;
    logic [CNT_W-1:0]  count_r;

    assign in_fire_s  = sample && rdy_s[0];
    assign out_fire_s = vld_s[DEPTH] && ack;
    assign count      = count_r;

    // Occupancy: net change of beats entering and leaving this cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= '0;
        end else begin
            case ({in_fire_s, out_fire_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_rho_pi.sv
// Directed bench for sha3_rho_pi: single-lane rho/pi vectors, 32-bit lanes,
// backpressure on a 3-deep pipe, streaming and reset on a 2-deep pipe.
module tb_sha3_rho_pi;

    typedef logic [24:0][63:0] st64_t;
    typedef logic [24:0][31:0] st32_t;

    typedef struct {
        int          sx;
        int          sy;
        logic [63:0] val;
        logic        pi;
        int          dx;
        int          dy;
        logic [63:0] exp;
    } vec_t;

    localparam int OFS [5][5] = '{
        '{ 0, 36,  3, 41, 18},
        '{ 1, 44, 10, 45,  2},
        '{62,  6, 43, 15, 61},
        '{28, 55, 25, 21, 56},
        '{27, 20, 39,  8, 14}
    };

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 64-bit lanes, single stage
    st64_t a_in;
    wire [24:0][63:0] a_out;
    logic a_sample, a_pi, a_ack;
    wire a_ready, a_good;
    wire [0:0] a_count;

    sha3_rho_pi #(.LANE_W(64), .DEPTH(1)) u_a (
        .clk(clk), .rst(rst),
        .isa(a_in[4:0]), .isb(a_in[9:5]), .isc(a_in[14:10]), .isd(a_in[19:15]), .ise(a_in[24:20]),
        .sample(a_sample), .apply_pi(a_pi), .ready(a_ready),
        .osa(a_out[4:0]), .osb(a_out[9:5]), .osc(a_out[14:10]), .osd(a_out[19:15]), .ose(a_out[24:20]),
        .good(a_good), .ack(a_ack), .count(a_count)
    );

    // 32-bit lanes, three stages
    st32_t b_in;
    wire [24:0][31:0] b_out;
    logic b_sample, b_pi, b_ack;
    wire b_ready, b_good;
    wire [1:0] b_count;

    sha3_rho_pi #(.LANE_W(32), .DEPTH(3)) u_b (
        .clk(clk), .rst(rst),
        .isa(b_in[4:0]), .isb(b_in[9:5]), .isc(b_in[14:10]), .isd(b_in[19:15]), .ise(b_in[24:20]),
        .sample(b_sample), .apply_pi(b_pi), .ready(b_ready),
        .osa(b_out[4:0]), .osb(b_out[9:5]), .osc(b_out[14:10]), .osd(b_out[19:15]), .ose(b_out[24:20]),
        .good(b_good), .ack(b_ack), .count(b_count)
    );

    // 64-bit lanes, two stages
    st64_t c_in;
    wire [24:0][63:0] c_out;
    logic c_sample, c_pi, c_ack;
    wire c_ready, c_good;
    wire [1:0] c_count;

    sha3_rho_pi #(.LANE_W(64), .DEPTH(2)) u_c (
        .clk(clk), .rst(rst),
        .isa(c_in[4:0]), .isb(c_in[9:5]), .isc(c_in[14:10]), .isd(c_in[19:15]), .ise(c_in[24:20]),
        .sample(c_sample), .apply_pi(c_pi), .ready(c_ready),
        .osa(c_out[4:0]), .osb(c_out[9:5]), .osc(c_out[14:10]), .osd(c_out[19:15]), .ose(c_out[24:20]),
        .good(c_good), .ack(c_ack), .count(c_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_st(input string name, input st64_t act, input st64_t exp);
        int bad;
        bad = -1;
        n_tests++;
        for (int i = 24; i >= 0; i--) begin
            if (act[i] !== exp[i]) bad = i;
        end
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: lane %0d got %h expected %h", name, bad, act[bad], exp[bad]);
        end
    endtask

    function automatic st64_t widen32(input st32_t s);
        st64_t r;
        for (int i = 0; i < 25; i++) r[i] = {32'h0, s[i]};
        return r;
    endfunction

    function automatic st64_t one_lane(input int x, input int y, input logic [63:0] v);
        st64_t r;
        r = '0;
        r[y * 5 + x] = v;
        return r;
    endfunction

    // Reference rho/pi on w-bit lanes, table indexed [x][y]
    function automatic st64_t model(input st64_t s, input logic pi, input int w);
        st64_t r;
        logic [63:0] mask, v, rot;
        int amt, dx, dy;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        r = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                v   = s[y * 5 + x] & mask;
                amt = OFS[x][y] % w;
                rot = (amt == 0) ? v : (((v << amt) | (v >> (w - amt))) & mask);
                if (pi) begin
                    dx = y;
                    dy = (2 * x + 3 * y) % 5;
                end else begin
                    dx = x;
                    dy = y;
                end
                r[dy * 5 + dx] = rot;
            end
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t  vecs [12];
        st64_t q [$];
        st64_t exp_s;
        logic [3:0] acc;
        int n_in, n_out;

        vecs[0]  = '{1, 0, 64'h1,                   1'b0, 1, 0, 64'h2};
        vecs[1]  = '{1, 0, 64'h1,                   1'b1, 0, 2, 64'h2};
        vecs[2]  = '{0, 0, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, 0, 64'hDEAD_BEEF_0123_4567};
        vecs[3]  = '{0, 0, 64'h0123_4567_89AB_CDEF, 1'b1, 0, 0, 64'h0123_4567_89AB_CDEF};
        vecs[4]  = '{1, 1, 64'h8000_0000_0000_0001, 1'b0, 1, 1, 64'h0000_1800_0000_0000};
        vecs[5]  = '{1, 1, 64'h8000_0000_0000_0001, 1'b1, 1, 0, 64'h0000_1800_0000_0000};
        vecs[6]  = '{4, 4, 64'h1,                   1'b1, 4, 0, 64'h4000};
        vecs[7]  = '{2, 3, 64'h1,                   1'b1, 3, 3, 64'h8000};
        vecs[8]  = '{3, 2, 64'h1,                   1'b1, 2, 2, 64'h200_0000};
        vecs[9]  = '{2, 4, 64'hF,                   1'b0, 2, 4, 64'hE000_0000_0000_0001};
        vecs[10] = '{3, 1, 64'h1,                   1'b1, 1, 4, 64'h0080_0000_0000_0000};
        vecs[11] = '{4, 0, 64'h1,                   1'b1, 0, 3, 64'h800_0000};

        rst = 1'b0;
        a_in = '0; a_sample = 1'b0; a_pi = 1'b0; a_ack = 1'b0;
        b_in = '0; b_sample = 1'b0; b_pi = 1'b0; b_ack = 1'b0;
        c_in = '0; c_sample = 1'b0; c_pi = 1'b0; c_ack = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_good", a_good, 1'b0);
        chk("rst_a_count", a_count, 1'b0);
        chk_st("rst_a_out", a_out, '0);
        chk("rst_b_good", b_good, 1'b0);
        chk("rst_b_count", b_count, 2'd0);
        chk_st("rst_c_out", c_out, '0);

        @(negedge clk);
        rst = 1'b1;
        chk("rst_a_ready", a_ready, 1'b1);

        // Single-lane directed vectors, one beat per cycle with ack held
        a_ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a_in     = one_lane(vecs[i].sx, vecs[i].sy, vecs[i].val);
            a_pi     = vecs[i].pi;
            a_sample = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_good", i), a_good, 1'b1);
            chk_st($sformatf("vec%0d_out", i), a_out, one_lane(vecs[i].dx, vecs[i].dy, vecs[i].exp));
        end
        @(negedge clk);
        a_sample = 1'b0;
        @(posedge clk);
        #1;
        chk("a_drain_good", a_good, 1'b0);
        chk("a_drain_count", a_count, 1'b0);

        // 32-bit lanes: offset 62 reduces to 30; latency of three stages
        b_ack = 1'b1;
        @(negedge clk);
        b_in = '0;
        b_in[2] = 32'h1;
        b_pi = 1'b0;
        b_sample = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_sample = 1'b0;
        chk("b_lat1_good", b_good, 1'b0);
        @(posedge clk);
        #1;
        chk("b_lat2_good", b_good, 1'b0);
        @(posedge clk);
        #1;
        chk("b_lat3_good", b_good, 1'b1);
        exp_s = '0;
        exp_s[2] = 64'h4000_0000;
        chk_st("b_w32_out", widen32(b_out), exp_s);
        @(posedge clk);
        #1;
        chk("b_after_good", b_good, 1'b0);

        // Backpressure: four beats offered into a 3-deep pipe with ack low
        b_ack = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            b_in = '0;
            b_in[0] = 32'(j + 1);
            b_sample = 1'b1;
            acc[j] = b_ready;
            @(posedge clk);
        end
        @(negedge clk);
        b_sample = 1'b0;
        chk("bp_accepted", acc, 4'b0111);
        chk("bp_count", b_count, 2'd3);
        chk("bp_ready", b_ready, 1'b0);
        @(negedge clk);
        chk("bp_hold_good", b_good, 1'b1);
        chk("bp_hold_out", b_out[0], 32'd1);
        b_ack = 1'b1;
        for (int k = 2; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_out%0d_good", k), b_good, 1'b1);
            chk($sformatf("bp_out%0d", k), b_out[0], 64'(k));
        end
        @(posedge clk);
        #1;
        chk("bp_empty_good", b_good, 1'b0);
        chk("bp_empty_count", b_count, 2'd0);

        // Streaming through a full 2-deep pipe against the reference model
        c_ack = 1'b1;
        n_in  = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 25; i++) c_in[i] = {$urandom, $urandom};
            c_pi = 1'($urandom_range(0, 1));
            c_sample = 1'b1;
            #1;
            if (c_good && c_ack) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream_underflow: output beat with nothing expected");
                end else begin
                    chk_st($sformatf("stream%0d", cyc), c_out, q.pop_front());
                end
                if (cyc >= 2) n_out++;
            end
            if (c_sample && c_ready) begin
                q.push_back(model(c_in, c_pi, 64));
                if (cyc >= 2) n_in++;
            end
            if (cyc >= 2) chk($sformatf("stream%0d_count", cyc), c_count, 2'd2);
            @(posedge clk);
        end
        chk("stream_in", n_in, 10);
        chk("stream_out", n_out, 10);

        // Reset with two beats in flight; sample/ack stay high and are ignored
        @(negedge clk);
        chk("prerst_count", c_count, 2'd2);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_good", c_good, 1'b0);
        chk("midrst_count", c_count, 2'd0);
        chk_st("midrst_out", c_out, '0);
        @(negedge clk);
        rst = 1'b1;
        c_sample = 1'b0;
        chk("postrst_ready", c_ready, 1'b1);
        c_in = one_lane(1, 0, 64'h1);
        c_pi = 1'b0;
        c_sample = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_sample = 1'b0;
        chk("postrst_lat1_good", c_good, 1'b0);
        @(posedge clk);
        #1;
        chk("postrst_lat2_good", c_good, 1'b1);
        chk_st("postrst_out", c_out, one_lane(1, 0, 64'h2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
